// File: rtl/iuq_uc_issue_seq.sv
// iuq_uc_issue_seq: microcode ROM walker with 2-entry prefetch queue issuing to the IB under backpressure and flush
module iuq_uc_issue_seq #(
  parameter int rom_addr_width = 10,
  parameter int instr_width    = 32
) (
  input  logic                      nclk,
  input  logic                      reset,
  input  logic                      uc_start,
  input  logic [rom_addr_width-1:0] uc_start_addr,
  input  logic                      flush,
  input  logic                      flush_into_uc,
  input  logic [rom_addr_width-1:0] flush_restart_addr,
  output logic                      rom_rd,
  output logic [rom_addr_width-1:0] rom_addr,
  input  logic [instr_width-1:0]    rom_data,
  input  logic                      rom_last,
  input  logic                      ib_ready,
  input  logic                      cplbuffer_full,
  output logic                      new_command,
  output logic [instr_width-1:0]    buff_instr_out,
  output logic                      uc_busy,
  output logic                      uc_done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                    state_q, state_d;
  logic [rom_addr_width-1:0] fetch_addr_q, fetch_addr_d;
  logic                      inflight_q, stop_fetch_q, stop_fetch_d;
  logic [1:0]                q_count_q, q_count_d;
  logic [instr_width:0]      q_q [2];
  logic [instr_width:0]      q_d [2];
  logic                      kill, issue, push, start_ok;
  logic [2:0]                occ;
  logic [1:0]                slot;
  assign kill     = flush | flush_into_uc;
  assign issue    = (q_count_q != 2'd0) & ib_ready & ~cplbuffer_full & ~kill;
  // occupancy after this cycle's pop decides whether another read may be launched
  assign occ      = {1'b0, q_count_q} + {2'b0, inflight_q} - {2'b0, issue};
  assign rom_rd   = (state_q == RUN) & ~stop_fetch_q & ~kill & (occ < 3'd2);
  assign push     = inflight_q & ~stop_fetch_q & ~kill;
  assign start_ok = (state_q == IDLE) & uc_start & ~kill;
  assign slot     = q_count_q - 2'(issue);
  assign rom_addr       = fetch_addr_q;
  assign new_command    = issue;
  assign buff_instr_out = q_q[0][instr_width:1];
  assign uc_busy        = state_q == RUN;
  assign uc_done        = issue & q_q[0][0];
  always_comb begin
    q_d = q_q;
    if (issue) q_d[0] = q_q[1];
    if (push) q_d[slot[0]] = {rom_data, rom_last};
    q_count_d    = kill ? 2'd0 : q_count_q - 2'(issue) + 2'(push);
    stop_fetch_d = (kill | start_ok) ? 1'b0 : (push & rom_last) ? 1'b1 : stop_fetch_q;
    fetch_addr_d = flush_into_uc ? flush_restart_addr :
                   start_ok      ? uc_start_addr :
                   rom_rd        ? fetch_addr_q + rom_addr_width'(1) : fetch_addr_q;
    state_d      = flush_into_uc ? RUN :
                   flush         ? IDLE :
                   start_ok      ? RUN :
                   uc_done       ? IDLE : state_q;
  end
  always_ff @(posedge nclk) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      inflight_q   <= 1'b0;
      stop_fetch_q <= 1'b0;
      q_count_q    <= 2'd0;
      q_q[0]       <= '0;
      q_q[1]       <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      inflight_q   <= rom_rd;
      stop_fetch_q <= stop_fetch_d;
      q_count_q    <= q_count_d;
      q_q          <= q_d;
    end
  end
  // the fetch rule keeps queue + inflight <= 2, so a push into a full queue is a design error
  assert property (@(posedge nclk) disable iff (reset) !(push && slot[1]));
endmodule

// File: doc/iuq_uc_issue_seq.md
# iuq_uc_issue_seq

Microcode issue sequencer for the IU microcode unit. It walks the microcode ROM from a start address and prefetches words into a 2-entry queue. Each word is issued to the instruction buffer as one `new_command` pulse, and issue is gated by IB backpressure and by the completion buffer's `cplbuffer_full`. On flush the block drops in-flight work. `flush_into_uc` restarts the sequence from a supplied address.

## Interface
Parameters:
- `rom_addr_width`, 10: ROM word address width.
- `instr_width`, 32: microcode instruction width.

Ports:
- `nclk`  in  1  clock. Single clock domain; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `uc_start`  in  1  begin a sequence. Ignored unless the FSM is IDLE.
- `uc_start_addr`  in  `rom_addr_width`  first ROM address of the sequence.
- `flush`  in  1  cancel the sequence.
- `flush_into_uc`  in  1  cancel, then restart from `flush_restart_addr`.
- `flush_restart_addr`  in  `rom_addr_width`  restart address.
- `rom_rd`  out  1  ROM read strobe. Data returns exactly 1 cycle later.
- `rom_addr`  out  `rom_addr_width`  ROM read address.
- `rom_data`  in  `instr_width`  ROM data, valid in the cycle after `rom_rd`.
- `rom_last`  in  1  returned word is the last word of the sequence.
- `ib_ready`  in  1  IB can accept an instruction this cycle.
- `cplbuffer_full`  in  1  completion buffer cannot take another entry.
- `new_command`  out  1  instruction issued this cycle, to IB and the completion buffer.
- `buff_instr_out`  out  `instr_width`  issued instruction. Equals the queue head whenever the queue is non-empty.
- `uc_busy`  out  1  FSM is not IDLE.
- `uc_done`  out  1  1-cycle pulse when the last word issues.

## Operation
FSM states:
- **IDLE**
  - `uc_start` loads `fetch_addr` ← `uc_start_addr` and moves to RUN.
- **RUN**
  - Fetches while `stop_fetch`=0.
  - Moves to IDLE in the cycle `uc_done` fires.

Flush handling (evaluated in every state):
- **Priority:** `reset` > `flush_into_uc` > `flush` > `uc_start`.
- **`flush`:**
  - Queue cleared, `inflight` cleared, `stop_fetch` cleared.
  - Next state IDLE.
  - No `rom_rd`, `new_command` or `uc_done` in that cycle.
- **`flush_into_uc`:**
  - Same clearing as `flush`.
  - Sets `fetch_addr` ← `flush_restart_addr`.
  - Next state RUN, regardless of the current state.

Fetch:
- `issue` = queue non-empty & `ib_ready` & ~`cplbuffer_full` & ~`flush` & ~`flush_into_uc`.
- `new_command` = `issue`.
- `rom_rd` = RUN & ~`stop_fetch` & ~`flush` & ~`flush_into_uc` & (`q_count` + `inflight` − `issue` < 2).
- `rom_addr` = `fetch_addr`.
- `fetch_addr` increments on each `rom_rd` and wraps modulo 2^`rom_addr_width`.

Return:
- `inflight` is a 1-bit register: set on `rom_rd`, cleared otherwise.
- When `inflight`=1 and the return is accepted, push {`rom_data`, `rom_last`} into the queue.
- Accepted means: `stop_fetch` was 0 at the start of the cycle, and no flush or `flush_into_uc` is active.
- A push with `rom_last`=1 sets `stop_fetch`. Any later return still in flight is discarded. At most one word is over-fetched.

Queue:
- 2 entries; each entry holds the instruction and its last bit.
- Push and pop in the same cycle are allowed.
- The queue never overflows, by construction of the fetch rule. Overflow is an assertion.

Completion:
- `uc_done` = `issue` & head.last.

Reset:
- IDLE.
- Queue empty, `inflight`=0, `stop_fetch`=0, `fetch_addr`=0.

Reset values of outputs: `rom_rd`=0, `rom_addr`=0, `new_command`=0, `buff_instr_out`=0, `uc_busy`=0, `uc_done`=0.

## Timing
- **Start latency:** `uc_start` at cycle T.
  - `rom_rd` with address A at T+1.
  - Data is pushed at T+2.
  - First `new_command` at T+3.
- **Throughput:** 1 instruction per cycle while `ib_ready`=1 and `cplbuffer_full`=0.
- **Stall:** `cplbuffer_full` or `ib_ready`=0 holds the head. After the stall clears, `new_command` rises the next cycle it is evaluated true, with the same instruction.
- **Flush:** takes effect in the same cycle it is asserted, on combinational outputs. In the following cycle:
  - The state is cleared.
  - A return from a read issued before the flush is ignored, because `inflight` was cleared.
- **`flush_into_uc` restart:** at cycle T, `rom_rd` of the restart address at T+1, `new_command` at T+3.
- **`uc_start` while RUN:** ignored.
- **`uc_start` in the same cycle as `uc_done`:** ignored. The FSM must be IDLE at the start of the cycle for `uc_start` to be accepted.

## Test plan
- **Basic 3-word sequence:**
  - Stimulus: `uc_start` at 0 with addr 0x010; `rom_last` on 0x012; `ib_ready`=1.
  - Required: `rom_rd` at cycles 1–4 (addresses 0x010–0x013); `new_command` at 3,4,5; `uc_done` at 5; the 0x013 word is dropped; `uc_busy` low at 6.
- **Completion buffer stall:**
  - Stimulus: `cplbuffer_full`=1 during cycles 4–6 of the basic sequence.
  - Required: at most 2 queued; `rom_rd` low while queue+`inflight`=2; issue resumes at 7 with word 0x011.
- **IB backpressure:**
  - Stimulus: `ib_ready` toggles every cycle.
  - Required: every word issued exactly once, in order; no queue overflow assertion.
- **Flush mid-sequence:**
  - Stimulus: `flush` at cycle 4 with a read in flight.
  - Required: no `new_command` at 4 or later; the in-flight return is discarded; IDLE at 5; a following `uc_start` runs cleanly.
- **`flush_into_uc` restart:**
  - Stimulus: assert at cycle 4 with restart addr 0x100.
  - Required: `rom_rd` of 0x100 at 5; first `new_command` at 7 carrying the ROM word at 0x100.
- **Address wrap:**
  - Stimulus: start at 0x3FF with `rom_addr_width`=10.
  - Required: second fetch address 0x000.
